// File: rtl/io_ctrl.sv
// io_ctrl: CPU-facing I/O controller bridging a CPU write/interrupt interface
// to a UART transmitter and receiver.
//
// Build option: IO_CTRL_TX_FIFO_EN
//   undefined : single-byte TX buffer, w_busy = buffer loaded OR FSM not idle
//   defined   : 4-entry TX FIFO, w_busy = FIFO full
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   w_req, w_data       : CPU write request pulse and the byte to send
//   w_busy              : write path cannot take a byte this cycle
//   ack, intr_en        : CPU receive acknowledge and interrupt enable
//   irr                 : interrupt request (pending AND intr_en)
//   r_data              : last received byte
//   rx_valid, rx_data   : UART receiver byte strobe and byte
//   tx_start, tx_data   : one-cycle start pulse and byte to the UART transmitter
//   tx_busy             : UART transmitter busy
//   rx_overrun, tx_drop : sticky error flags, cleared only by rst
module io_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       w_req,
  input  logic [7:0] w_data,
  output logic       w_busy,
  input  logic       ack,
  input  logic       intr_en,
  output logic       irr,
  output logic [7:0] r_data,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       rx_overrun,
  output logic       tx_drop
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LAUNCH  = 2'd1;
  localparam logic [1:0] ST_WAIT_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

  logic [1:0] state_q, state_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       pending_q, pending_d;
  logic [7:0] r_data_q, r_data_d;
  logic       rx_overrun_q, rx_overrun_d;
  logic       tx_drop_q, tx_drop_d;

  logic       avail_s;   // a byte is waiting to be launched
  logic [7:0] head_s;    // the byte that would be launched next
  logic       pop_s;     // in-flight byte is released this cycle
  logic       accept_s;  // w_req is taken this cycle
  logic       w_busy_s;

  // TX FSM next state; tx_start is registered so it is high exactly while in LAUNCH
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (avail_s) begin
          state_d    = ST_LAUNCH;
          tx_start_d = 1'b1;
          tx_data_d  = head_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        // no timeout: wait as long as the transmitter takes to respond
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end else begin
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
          pop_s   = 1'b1;
        end else begin
          state_d = ST_WAIT_LO;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // TX FSM and launch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

`ifdef IO_CTRL_TX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       full_s;

  assign full_s   = (count_q == 3'd4);
  assign w_busy_s = full_s;
  // a pop frees a slot in the same cycle, so a full FIFO may still take a push
  assign accept_s = w_req & (~full_s | pop_s);
  assign avail_s  = (count_q != 3'd0);
  // the head entry stays in the FIFO until its transfer completes
  assign head_s   = mem_q[rd_ptr_q];

  // FIFO pointer and count next state; pointers wrap naturally at 2 bits
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers and count
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (accept_s) begin
        mem_q[wr_ptr_q] <= w_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  logic       buf_valid_q, buf_valid_d;
  logic [7:0] buf_data_q, buf_data_d;

  // the buffer holds its byte until the transfer ends, so busy covers the whole flight
  assign w_busy_s = buf_valid_q | (state_q != ST_IDLE);
  assign accept_s = w_req & ~w_busy_s;
  assign avail_s  = buf_valid_q;
  assign head_s   = buf_data_q;

  // single buffer next state; accept and release never coincide
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (accept_s) begin
      buf_valid_d = 1'b1;
      buf_data_d  = w_data;
    end else if (pop_s) begin
      buf_valid_d = 1'b0;
    end else begin
      buf_valid_d = buf_valid_q;
    end
  end

  // single buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= 8'h00;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
    end
  end
`endif

  // RX path and sticky flags; rx_valid wins over ack in the same cycle
  always_comb begin
    pending_d    = pending_q;
    r_data_d     = r_data_q;
    rx_overrun_d = rx_overrun_q;
    tx_drop_d    = tx_drop_q | (w_req & ~accept_s);
    if (rx_valid) begin
      pending_d = 1'b1;
      r_data_d  = rx_data;
      if (pending_q && !ack) begin
        rx_overrun_d = 1'b1;
      end else begin
        rx_overrun_d = rx_overrun_q;
      end
    end else if (ack) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // RX and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= 1'b0;
      r_data_q     <= 8'h00;
      rx_overrun_q <= 1'b0;
      tx_drop_q    <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      r_data_q     <= r_data_d;
      rx_overrun_q <= rx_overrun_d;
      tx_drop_q    <= tx_drop_d;
    end
  end

  assign w_busy     = w_busy_s;
  assign irr        = pending_q & intr_en;
  assign r_data     = r_data_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign rx_overrun = rx_overrun_q;
  assign tx_drop    = tx_drop_q;

endmodule
